l15_req_arbiter: RTL and testbench
==================================

Name: l15_req_arbiter

Overview:
- Shares the single L1.5 request/return port of a tile between NumReq requesters, for example the core cache subsystem and a debug/DMA engine.
- Requests are arbitrated round-robin and driven onto L15 with a registered valid/header_ack handshake.
- Each accepted request gets a free L15 thread-id tag. Returns are routed back to the owner using an outstanding-transaction table.
- Sits between the requester-side cache adapters and the flattened L15 request/return vectors at the tile wrapper boundary.

Parameters:
- NumReq, 2: number of requesters.
- PayloadWidth, 128: request fields other than valid/tid, passed opaquely.
- RtrnWidth, 128: return fields other than valid/tid, passed opaquely.
- TidWidth, 2: L15-side tag width; table depth NumTags = 2**TidWidth.
- ReqTidWidth, 1: requester-local tid width, restored on return.

Ports:
- clk_i  in  1  clock
- reset_l  in  1  asynchronous, active-low reset
- req_val_i  in  NumReq  request valid per requester
- req_payload_i  in  NumReq*PayloadWidth  request payloads
- req_tid_i  in  NumReq*ReqTidWidth  requester-local tids
- req_ack_o  out  NumReq  one-hot pulse: request captured
- l15_val_o  out  1  L15 request valid
- l15_payload_o  out  PayloadWidth  L15 request payload
- l15_tid_o  out  TidWidth  allocated tag
- l15_header_ack_i  in  1  L15 accepted request
- l15_rtrn_val_i  in  1  return valid
- l15_rtrn_unsol_i  in  1  return is unsolicited (interrupt/invalidation); no tag
- l15_rtrn_tid_i  in  TidWidth  return tag
- l15_rtrn_payload_i  in  RtrnWidth  return payload
- l15_rtrn_ack_o  out  1  return consumed
- rtrn_val_o  out  NumReq  per-requester return valid
- rtrn_tid_o  out  ReqTidWidth  restored local tid
- rtrn_payload_o  out  RtrnWidth  shared return payload
- rtrn_ack_i  in  NumReq  requester consumed return
- busy_o  out  1  any tag outstanding or L15 request pending
- err_o  out  1  sticky: return with unallocated tag

Behaviour:
- Reset (reset_l low, async): l15_val_o=0, l15_payload_o=0, l15_tid_o=0, all table entries invalid, RR pointer=0, err_o=0. All combinational outputs are 0 while reset is held. Reset mid-transaction drops all state; no recovery of in-flight tags.
- Request FSM, two states:
  - IDLE → HOLD when any req_val_i is high and a free tag exists.
  - HOLD → IDLE on l15_header_ack_i, unless a new grant occurs in the same cycle, in which case it stays in HOLD with the new request loaded (back-to-back, 1 request/cycle max).
- Grant (combinational) is allowed in IDLE, or in HOLD when l15_header_ack_i=1. The grant:
  - pulses req_ack_o[g] for that cycle;
  - allocates the lowest-index free tag;
  - writes table[tag] = {valid, owner=g, local_tid};
  - registers payload/tag so l15_val_o rises the next cycle.
- Requester rule: hold req_val_i and the payload stable until req_ack_o.
- Output stability: l15_payload_o and l15_tid_o stay stable while l15_val_o=1 and header_ack is absent.
- Round-robin: the pointer moves to g+1 mod NumReq after each grant. Search order is pointer, pointer+1, and so on.
- All tags valid → no grant. req_ack_o stays 0 and requesters wait.
- Return path, combinational, no added latency:
  - Solicited return (l15_rtrn_unsol_i=0) with table[l15_rtrn_tid_i] valid:
    - rtrn_val_o[owner]=1 and rtrn_tid_o=local_tid;
    - l15_rtrn_ack_o = rtrn_ack_i[owner];
    - on l15_rtrn_val_i & l15_rtrn_ack_o, the entry is cleared at the clock edge.
  - Unsolicited return: routed to requester 0 with rtrn_tid_o=0; the table is untouched.
  - Solicited return with an invalid tag: l15_rtrn_ack_o=1 immediately (drop), no rtrn_val_o, err_o set until reset.
- rtrn_payload_o = l15_rtrn_payload_i at all times.
- Simultaneous free and allocate in one cycle: allowed. The allocate uses pre-edge free state, so a tag freed this cycle is reusable next cycle.
- Each request gets exactly one solicited return. Returns may arrive in any order.
- busy_o = l15_val_o | any table valid.

Decomposition:
- Package l15_arb_pkg holds:
  - tag_entry_t {valid, owner[$clog2(NumReq)], local_tid};
  - localparam NumTags;
  - helper function for the owner index width (minimum 1).
- Sub-modules:
  - free-tag selection uses the existing lzc from common_cells;
  - round-robin selection is one sub-module, l15_rr_picker (request vector + pointer → one-hot grant + index).

Test Plan:
1. Reset, then req_val_i=2'b01, header_ack held 0 → req_ack_o=01 in cycle 0; l15_val_o=1, tid=0 from cycle 1 with stable payload; ack in cycle 4 → l15_val_o=0 in cycle 5.
2. Both requesters continuously valid, header_ack=1 every cycle, returns immediate → grants alternate 0,1,0,1, one request per cycle, tags 0,1,2,3 then reused.
3. Four requests from requester 1 without returns (TidWidth=2) → 5th not acked. A return on tag 2 with rtrn_ack_i[1]=1 frees it, and the 5th is granted tag 2 the next cycle.
4. Out-of-order returns: tag 1 (owner 0, local tid 1) then tag 0 (owner 1, local tid 0) → rtrn_val_o=01 with rtrn_tid_o=1, then rtrn_val_o=10 with rtrn_tid_o=0. l15_rtrn_ack_o follows the owner's ack and stalls while rtrn_ack_i=0.
5. Return on an unallocated tag 3 → l15_rtrn_ack_o=1, rtrn_val_o=00, err_o=1 until reset. An unsolicited return goes to requester 0 and leaves table occupancy unchanged.
6. Assert reset_l low with 3 tags outstanding and l15_val_o=1 → all outputs 0 asynchronously. After release, busy_o=0 and the first grant gets tag 0.

Source files
------------

// File: rtl/l15_arb_pkg.sv
// Shared types and configuration for the L1.5 request arbiter.
// tag_entry_t and NumTags are sized from the package configuration below.
package l15_arb_pkg;

    localparam int unsigned NumReqDef      = 2;
    localparam int unsigned TidWidthDef    = 2;
    localparam int unsigned ReqTidWidthDef = 1;
    localparam int unsigned NumTags        = 2 ** TidWidthDef;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned OwnerWidth = idx_width(NumReqDef);

    typedef struct packed {
        logic                      valid;
        logic [OwnerWidth-1:0]     owner;
        logic [ReqTidWidthDef-1:0] local_tid;
    } tag_entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } req_state_e;

endpackage

// File: rtl/l15_rr_picker.sv
// Round-robin picker: first requester at or after ptr_i, wrapping around.
module l15_rr_picker
    import l15_arb_pkg::*;
#(
    parameter int unsigned NumReq   = NumReqDef,
    parameter int unsigned IdxWidth = idx_width(NumReq)
) (
    input  logic [NumReq-1:0]   req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_o
);

    logic [NumReq-1:0] req_rot;
    int                pos;

    // Bit k of req_rot is requester (ptr_i + k) mod NumReq.
    assign req_rot = NumReq'({req_i, req_i} >> ptr_i);

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                any_o = 1'b1;
                pos   = int'(ptr_i) + k;
                if (pos >= int'(NumReq)) pos = pos - int'(NumReq);
                idx_o = IdxWidth'(pos);
            end
        end
        gnt_o = any_o ? (NumReq'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/lzc.sv
// Leading/trailing zero counter (MODE=0: trailing zeros, i.e. index of lowest set bit).
module lzc #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        if (!MODE) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
        empty_o = ~|in_i;
    end

endmodule

// File: rtl/l15_req_arbiter.sv
// Shares one L1.5 request/return port between NumReq requesters: round-robin
// grant, L15 tag allocation, and return routing via an outstanding-tag table.
module l15_req_arbiter
    import l15_arb_pkg::*;
#(
    parameter int unsigned NumReq       = NumReqDef,
    parameter int unsigned PayloadWidth = 128,
    parameter int unsigned RtrnWidth    = 128,
    parameter int unsigned TidWidth     = TidWidthDef,
    parameter int unsigned ReqTidWidth  = ReqTidWidthDef
) (
    input  logic                           clk_i,
    input  logic                           reset_l,
    input  logic [NumReq-1:0]              req_val_i,
    input  logic [NumReq*PayloadWidth-1:0] req_payload_i,
    input  logic [NumReq*ReqTidWidth-1:0]  req_tid_i,
    output logic [NumReq-1:0]              req_ack_o,
    output logic                           l15_val_o,
    output logic [PayloadWidth-1:0]        l15_payload_o,
    output logic [TidWidth-1:0]            l15_tid_o,
    input  logic                           l15_header_ack_i,
    input  logic                           l15_rtrn_val_i,
    input  logic                           l15_rtrn_unsol_i,
    input  logic [TidWidth-1:0]            l15_rtrn_tid_i,
    input  logic [RtrnWidth-1:0]           l15_rtrn_payload_i,
    output logic                           l15_rtrn_ack_o,
    output logic [NumReq-1:0]              rtrn_val_o,
    output logic [ReqTidWidth-1:0]         rtrn_tid_o,
    output logic [RtrnWidth-1:0]           rtrn_payload_o,
    input  logic [NumReq-1:0]              rtrn_ack_i,
    output logic                           busy_o,
    output logic                           err_o
);

    // Handshakes: a requester holds req_val_i/payload/tid until req_ack_o pulses;
    // l15_val_o holds payload/tid until l15_header_ack_i; a return is consumed
    // in the cycle l15_rtrn_val_i and l15_rtrn_ack_o are both high.

    req_state_e               state_q, state_d;
    tag_entry_t               table_q [NumTags];
    logic [OwnerWidth-1:0]    rr_ptr_q, pick_idx;
    logic [NumReq-1:0]        pick_gnt;
    logic                     pick_any;
    logic [NumTags-1:0]       free_vec;
    logic                     any_valid;
    logic [TidWidth-1:0]      free_tag;
    logic                     no_free;
    logic                     grant;
    logic [PayloadWidth-1:0]  sel_payload, payload_q;
    logic [ReqTidWidth-1:0]   sel_tid;
    logic [TidWidth-1:0]      tid_q;
    logic                     err_q;
    tag_entry_t               rt_entry;
    logic                     rtrn_sol, rtrn_uns, rtrn_hit, rtrn_miss, rtrn_free;

    always_comb begin
        any_valid = 1'b0;
        for (int t = 0; t < NumTags; t++) begin
            free_vec[t] = ~table_q[t].valid;
            any_valid   = any_valid | table_q[t].valid;
        end
    end

    lzc #(
        .WIDTH (NumTags),
        .MODE  (1'b0)
    ) i_free_lzc (
        .in_i    (free_vec),
        .cnt_o   (free_tag),
        .empty_o (no_free)
    );

    l15_rr_picker #(
        .NumReq   (NumReq),
        .IdxWidth (OwnerWidth)
    ) i_rr_picker (
        .req_i (req_val_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // A new grant may replace the held request in the cycle it is accepted.
    assign grant = reset_l & pick_any & ~no_free &
                   ((state_q == S_IDLE) | l15_header_ack_i);
    assign req_ack_o = grant ? pick_gnt : '0;

    always_comb begin
        sel_payload = '0;
        sel_tid     = '0;
        for (int r = 0; r < NumReq; r++) begin
            if (pick_gnt[r]) begin
                sel_payload = req_payload_i[r*PayloadWidth +: PayloadWidth];
                sel_tid     = req_tid_i[r*ReqTidWidth +: ReqTidWidth];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant) state_d = S_HOLD;
            S_HOLD:  if (l15_header_ack_i && !grant) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rt_entry  = table_q[l15_rtrn_tid_i];
    assign rtrn_sol  = reset_l & l15_rtrn_val_i & ~l15_rtrn_unsol_i;
    assign rtrn_uns  = reset_l & l15_rtrn_val_i & l15_rtrn_unsol_i;
    assign rtrn_hit  = rtrn_sol & rt_entry.valid;
    assign rtrn_miss = rtrn_sol & ~rt_entry.valid;

    always_comb begin
        rtrn_val_o     = '0;
        rtrn_tid_o     = '0;
        l15_rtrn_ack_o = 1'b0;
        if (rtrn_hit) begin
            rtrn_val_o[rt_entry.owner] = 1'b1;
            rtrn_tid_o                 = rt_entry.local_tid;
            l15_rtrn_ack_o             = rtrn_ack_i[rt_entry.owner];
        end else if (rtrn_uns) begin
            rtrn_val_o[0]  = 1'b1;
            l15_rtrn_ack_o = rtrn_ack_i[0];
        end else if (rtrn_miss) begin
            // Unknown tag: swallow the return so L15 does not stall.
            l15_rtrn_ack_o = 1'b1;
        end
    end

    assign rtrn_free = rtrn_hit & l15_rtrn_ack_o;

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= S_IDLE;
            payload_q <= '0;
            tid_q     <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
            for (int t = 0; t < NumTags; t++) table_q[t] <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                payload_q         <= sel_payload;
                tid_q             <= free_tag;
                rr_ptr_q          <= (pick_idx == OwnerWidth'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
                table_q[free_tag] <= '{valid: 1'b1, owner: pick_idx, local_tid: sel_tid};
            end
            if (rtrn_free) table_q[l15_rtrn_tid_i].valid <= 1'b0;
            if (rtrn_miss) err_q <= 1'b1;
        end
    end

    assign l15_val_o      = (state_q == S_HOLD);
    assign l15_payload_o  = payload_q;
    assign l15_tid_o      = tid_q;
    assign rtrn_payload_o = reset_l ? l15_rtrn_payload_i : '0;
    assign busy_o         = l15_val_o | any_valid;
    assign err_o          = err_q;

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Directed bench for l15_req_arbiter: a transaction-level model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_l15_req_arbiter;

    localparam int NR = 2;
    localparam int PW = 128;
    localparam int RW = 128;
    localparam int TW = 2;
    localparam int NT = 4;

    logic              clk_i;
    logic              reset_l;
    logic [NR-1:0]     req_val_i;
    logic [NR*PW-1:0]  req_payload_i;
    logic [NR-1:0]     req_tid_i;
    logic [NR-1:0]     req_ack_o;
    logic              l15_val_o;
    logic [PW-1:0]     l15_payload_o;
    logic [TW-1:0]     l15_tid_o;
    logic              l15_header_ack_i;
    logic              l15_rtrn_val_i;
    logic              l15_rtrn_unsol_i;
    logic [TW-1:0]     l15_rtrn_tid_i;
    logic [RW-1:0]     l15_rtrn_payload_i;
    logic              l15_rtrn_ack_o;
    logic [NR-1:0]     rtrn_val_o;
    logic [0:0]        rtrn_tid_o;
    logic [RW-1:0]     rtrn_payload_o;
    logic [NR-1:0]     rtrn_ack_i;
    logic              busy_o;
    logic              err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0] exp_q[$];

    l15_req_arbiter dut (
        .clk_i              (clk_i),
        .reset_l            (reset_l),
        .req_val_i          (req_val_i),
        .req_payload_i      (req_payload_i),
        .req_tid_i          (req_tid_i),
        .req_ack_o          (req_ack_o),
        .l15_val_o          (l15_val_o),
        .l15_payload_o      (l15_payload_o),
        .l15_tid_o          (l15_tid_o),
        .l15_header_ack_i   (l15_header_ack_i),
        .l15_rtrn_val_i     (l15_rtrn_val_i),
        .l15_rtrn_unsol_i   (l15_rtrn_unsol_i),
        .l15_rtrn_tid_i     (l15_rtrn_tid_i),
        .l15_rtrn_payload_i (l15_rtrn_payload_i),
        .l15_rtrn_ack_o     (l15_rtrn_ack_o),
        .rtrn_val_o         (rtrn_val_o),
        .rtrn_tid_o         (rtrn_tid_o),
        .rtrn_payload_o     (rtrn_payload_o),
        .rtrn_ack_i         (rtrn_ack_i),
        .busy_o             (busy_o),
        .err_o              (err_o)
    );

    // Clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected summary before 100000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int k);
        return {4{32'hC0DE_0000 | k}};
    endfunction

    // Driver tasks
    task automatic drive_idle();
        req_val_i          = '0;
        req_payload_i      = '0;
        req_tid_i          = '0;
        l15_header_ack_i   = 1'b0;
        l15_rtrn_val_i     = 1'b0;
        l15_rtrn_unsol_i   = 1'b0;
        l15_rtrn_tid_i     = '0;
        l15_rtrn_payload_i = '0;
        rtrn_ack_i         = '0;
    endtask

    task automatic set_req(input int r, input logic [127:0] p, input logic t);
        req_payload_i[r*PW +: PW] = p;
        req_tid_i[r]              = t;
    endtask

    task automatic set_rtrn(input logic v, input logic unsol, input logic [TW-1:0] tid,
                            input logic [127:0] p);
        l15_rtrn_val_i     = v;
        l15_rtrn_unsol_i   = unsol;
        l15_rtrn_tid_i     = tid;
        l15_rtrn_payload_i = p;
    endtask

    task automatic sample();
        @(negedge clk_i);
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk_i);
        #1;
        reset_l = 1'b1;
    endtask

    // Transaction-level model: outstanding tags, the pending L15 request and
    // the fairness pointer; compared against the DUT on every negedge.
    logic         m_l15_val;
    logic [127:0] m_payload;
    int           m_tid;
    int           m_ptr;
    logic         m_err;
    logic         m_v   [NT];
    int           m_own [NT];
    logic         m_lt  [NT];

    always @(negedge clk_i) begin : model_cmp
        int         ftag, gnt_r, tid;
        logic [1:0] e_ack, e_rv;
        logic       e_rt, e_ra, e_busy, do_free, do_err;
        if (!reset_l) begin
            m_l15_val = 1'b0;
            m_payload = '0;
            m_tid     = 0;
            m_ptr     = 0;
            m_err     = 1'b0;
            for (int t = 0; t < NT; t++) begin
                m_v[t] = 1'b0; m_own[t] = 0; m_lt[t] = 1'b0;
            end
            check("rst_req_ack", req_ack_o, 0);
            check("rst_l15_val", l15_val_o, 0);
            check("rst_l15_payload", l15_payload_o, 0);
            check("rst_l15_tid", l15_tid_o, 0);
            check("rst_l15_rtrn_ack", l15_rtrn_ack_o, 0);
            check("rst_rtrn_val", rtrn_val_o, 0);
            check("rst_rtrn_payload", rtrn_payload_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_err", err_o, 0);
        end else begin
            ftag = -1;
            for (int t = 0; t < NT; t++) if (!m_v[t] && ftag < 0) ftag = t;
            gnt_r = -1;
            if ((!m_l15_val || l15_header_ack_i) && ftag >= 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (gnt_r < 0 && req_val_i[(m_ptr + k) % NR]) gnt_r = (m_ptr + k) % NR;
                end
            end
            e_ack = (gnt_r >= 0) ? (2'b01 << gnt_r) : 2'b00;

            e_rv = 2'b00; e_rt = 1'b0; e_ra = 1'b0; do_free = 1'b0; do_err = 1'b0;
            tid = int'(l15_rtrn_tid_i);
            if (l15_rtrn_val_i) begin
                if (l15_rtrn_unsol_i) begin
                    e_rv = 2'b01; e_ra = rtrn_ack_i[0];
                end else if (m_v[tid]) begin
                    e_rv = 2'b01 << m_own[tid];
                    e_rt = m_lt[tid];
                    e_ra = rtrn_ack_i[m_own[tid]];
                    do_free = e_ra;
                end else begin
                    e_ra = 1'b1; do_err = 1'b1;
                end
            end
            e_busy = m_l15_val;
            for (int t = 0; t < NT; t++) e_busy = e_busy | m_v[t];

            check("m_req_ack", req_ack_o, e_ack);
            check("m_l15_val", l15_val_o, m_l15_val);
            if (m_l15_val) begin
                check("m_l15_payload", l15_payload_o, m_payload);
                check("m_l15_tid", l15_tid_o, m_tid);
            end
            check("m_rtrn_val", rtrn_val_o, e_rv);
            if (e_rv != 0) check("m_rtrn_tid", rtrn_tid_o, e_rt);
            check("m_l15_rtrn_ack", l15_rtrn_ack_o, e_ra);
            check("m_rtrn_payload", rtrn_payload_o, l15_rtrn_payload_i);
            check("m_busy", busy_o, e_busy);
            check("m_err", err_o, m_err);

            if (do_free) m_v[tid] = 1'b0;
            if (do_err) m_err = 1'b1;
            if (gnt_r >= 0) begin
                m_v[ftag]   = 1'b1;
                m_own[ftag] = gnt_r;
                m_lt[ftag]  = req_tid_i[gnt_r];
                m_l15_val   = 1'b1;
                m_payload   = req_payload_i[gnt_r*PW +: PW];
                m_tid       = ftag;
                m_ptr       = (gnt_r + 1) % NR;
            end else if (m_l15_val && l15_header_ack_i) begin
                m_l15_val = 1'b0;
            end
        end
    end

    // Directed scenarios
    initial begin
        logic prev_owner;
        logic [2:0] exp_e;
        reset_l = 1'b0;
        drive_idle();

        // 1: single request, header_ack delayed until cycle 4
        do_reset();
        set_req(0, pat(1), 1'b0);
        req_val_i = 2'b01;
        sample();
        check("t1_ack_c0", req_ack_o, 2'b01);
        check("t1_val_c0", l15_val_o, 0);
        tick();
        req_val_i = 2'b00;
        set_req(0, pat(9), 1'b0);
        for (int c = 1; c <= 4; c++) begin
            l15_header_ack_i = (c == 4);
            sample();
            check("t1_val", l15_val_o, 1);
            check("t1_tid", l15_tid_o, 0);
            check("t1_payload", l15_payload_o, pat(1));
            tick();
        end
        l15_header_ack_i = 1'b0;
        sample();
        check("t1_val_c5", l15_val_o, 0);
        check("t1_busy_c5", busy_o, 1);
        tick();

        // 2: both requesters streaming, returns three cycles after each grant
        do_reset();
        exp_q = {3'b000, 3'b101, 3'b010, 3'b111, 3'b000, 3'b101, 3'b010, 3'b111};
        set_req(0, pat(20), 1'b1);
        set_req(1, pat(21), 1'b0);
        l15_header_ack_i = 1'b1;
        rtrn_ack_i = 2'b11;
        prev_owner = 1'b0;
        for (int c = 0; c < 11; c++) begin
            req_val_i = (c < 8) ? 2'b11 : 2'b00;
            if (c >= 3) set_rtrn(1'b1, 1'b0, TW'((c - 3) % 4), pat(100 + c));
            else        set_rtrn(1'b0, 1'b0, '0, '0);
            sample();
            if (c >= 1 && c <= 8 && exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                check("t2_owner_tag", {prev_owner, l15_tid_o}, exp_e);
            end
            if (c < 8) begin
                check("t2_ack", req_ack_o, (c % 2 == 0) ? 2'b01 : 2'b10);
                prev_owner = req_ack_o[1];
            end
            tick();
        end
        drive_idle();
        sample();
        check("t2_busy_end", busy_o, 0);
        tick();

        // 3: table full stalls requester 1 until tag 2 is returned
        do_reset();
        set_req(1, pat(30), 1'b1);
        req_val_i = 2'b10;
        l15_header_ack_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sample();
            check("t3_ack", req_ack_o, (c < 4) ? 2'b10 : 2'b00);
            tick();
        end
        set_rtrn(1'b1, 1'b0, 2'd2, pat(31));
        rtrn_ack_i = 2'b10;
        sample();
        check("t3_full_ack", req_ack_o, 2'b00);
        check("t3_rtrn_val", rtrn_val_o, 2'b10);
        check("t3_rtrn_tid", rtrn_tid_o, 1);
        check("t3_l15_rtrn_ack", l15_rtrn_ack_o, 1);
        tick();
        set_rtrn(1'b0, 1'b0, '0, '0);
        rtrn_ack_i = 2'b00;
        sample();
        check("t3_regrant", req_ack_o, 2'b10);
        tick();
        req_val_i = 2'b00;
        sample();
        check("t3_tid_reuse", l15_tid_o, 2);
        check("t3_val_reuse", l15_val_o, 1);
        tick();

        // 4: out-of-order returns with owner back-pressure
        do_reset();
        set_req(1, pat(40), 1'b0);
        req_val_i = 2'b10;
        sample();
        check("t4_ack_r1", req_ack_o, 2'b10);
        tick();
        set_req(0, pat(41), 1'b1);
        req_val_i = 2'b01;
        l15_header_ack_i = 1'b1;
        sample();
        check("t4_ack_r0", req_ack_o, 2'b01);
        tick();
        req_val_i = 2'b00;
        sample();
        check("t4_tid1", l15_tid_o, 1);
        tick();
        l15_header_ack_i = 1'b0;
        set_rtrn(1'b1, 1'b0, 2'd1, pat(42));
        rtrn_ack_i = 2'b00;
        sample();
        check("t4_rv_tag1", rtrn_val_o, 2'b01);
        check("t4_rt_tag1", rtrn_tid_o, 1);
        check("t4_stall_tag1", l15_rtrn_ack_o, 0);
        tick();
        rtrn_ack_i = 2'b01;
        sample();
        check("t4_ack_tag1", l15_rtrn_ack_o, 1);
        tick();
        set_rtrn(1'b1, 1'b0, 2'd0, pat(43));
        rtrn_ack_i = 2'b01;
        sample();
        check("t4_rv_tag0", rtrn_val_o, 2'b10);
        check("t4_rt_tag0", rtrn_tid_o, 0);
        check("t4_wrong_owner", l15_rtrn_ack_o, 0);
        tick();
        rtrn_ack_i = 2'b10;
        sample();
        check("t4_ack_tag0", l15_rtrn_ack_o, 1);
        tick();
        drive_idle();
        sample();
        check("t4_busy_end", busy_o, 0);
        tick();

        // 5: return on an unallocated tag, then an unsolicited return
        do_reset();
        set_rtrn(1'b1, 1'b0, 2'd3, pat(50));
        sample();
        check("t5_drop_ack", l15_rtrn_ack_o, 1);
        check("t5_drop_rv", rtrn_val_o, 2'b00);
        check("t5_err_pre", err_o, 0);
        tick();
        set_rtrn(1'b0, 1'b0, '0, '0);
        set_req(0, pat(52), 1'b1);
        req_val_i = 2'b01;
        sample();
        check("t5_err_set", err_o, 1);
        tick();
        req_val_i = 2'b00;
        l15_header_ack_i = 1'b1;
        set_rtrn(1'b1, 1'b1, 2'd0, pat(51));
        rtrn_ack_i = 2'b01;
        sample();
        check("t5_unsol_rv", rtrn_val_o, 2'b01);
        check("t5_unsol_rt", rtrn_tid_o, 0);
        check("t5_unsol_ack", l15_rtrn_ack_o, 1);
        check("t5_unsol_payload", rtrn_payload_o, pat(51));
        tick();
        l15_header_ack_i = 1'b0;
        set_rtrn(1'b0, 1'b0, '0, '0);
        sample();
        check("t5_busy_kept", busy_o, 1);
        tick();
        set_rtrn(1'b1, 1'b0, 2'd0, pat(53));
        sample();
        check("t5_sol_rv", rtrn_val_o, 2'b01);
        check("t5_sol_rt", rtrn_tid_o, 1);
        tick();
        set_rtrn(1'b0, 1'b0, '0, '0);
        rtrn_ack_i = 2'b00;
        sample();
        check("t5_busy_end", busy_o, 0);
        check("t5_err_sticky", err_o, 1);
        tick();

        // 6: asynchronous reset with three tags out and a request pending
        do_reset();
        set_req(0, pat(60), 1'b0);
        set_req(1, pat(61), 1'b1);
        req_val_i = 2'b11;
        l15_header_ack_i = 1'b1;
        repeat (3) begin
            sample();
            tick();
        end
        l15_header_ack_i = 1'b0;
        set_rtrn(1'b1, 1'b1, 2'd0, pat(62));
        rtrn_ack_i = 2'b01;
        sample();
        check("t6_val_pre", l15_val_o, 1);
        check("t6_tid_pre", l15_tid_o, 2);
        check("t6_rv_pre", rtrn_val_o, 2'b01);
        reset_l = 1'b0;
        #1;
        check("t6_async_val", l15_val_o, 0);
        check("t6_async_payload", l15_payload_o, 0);
        check("t6_async_tid", l15_tid_o, 0);
        check("t6_async_req_ack", req_ack_o, 0);
        check("t6_async_rv", rtrn_val_o, 0);
        check("t6_async_rtrn_ack", l15_rtrn_ack_o, 0);
        check("t6_async_rpayload", rtrn_payload_o, 0);
        check("t6_async_busy", busy_o, 0);
        do_reset();
        sample();
        check("t6_busy_post", busy_o, 0);
        tick();
        set_req(0, pat(63), 1'b0);
        set_req(1, pat(64), 1'b1);
        req_val_i = 2'b11;
        sample();
        check("t6_first_ack", req_ack_o, 2'b01);
        tick();
        req_val_i = 2'b00;
        sample();
        check("t6_first_tid", l15_tid_o, 0);
        check("t6_first_payload", l15_payload_o, pat(63));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
